gpio_bus_initiator: RTL

- Register-bus initiator that drives the GPIO/ADC address-decoder register bus (chip_sel, read_reg, write_reg, busaddress, busdata) from an Avalon-MM slave port on the HPS/lightweight bridge side.
- Serialises one transaction at a time and generates strobes with fixed width and fixed hold/recovery. The decoder registers strobes through a multi-stage pipeline and clocks its registers on the strobe edge, so it needs these timings.
- Captures read-return data at a fixed latency and returns it with readdatavalid.

---
 rtl/gpio_bus_initiator.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/gpio_bus_initiator.sv
// gpio_bus_initiator
// Purpose: Avalon-MM slave to GPIO/ADC address-decoder register bus bridge.
//          Runs one register transaction at a time with a fixed strobe width,
//          a fixed strobe-to-sample / hold time and fixed recovery, so the
//          decoder's pipelined strobe capture always sees stable address/data.
// Ports:
//   reg_clk, reset_in             clock, synchronous active-high reset
//   avs_address/read/write/...    Avalon-MM slave (word addressed)
//   avs_waitrequest               request not accepted this cycle (comb in IDLE)
//   avs_readdata/readdatavalid    read return, one-cycle valid pulse
//   chip_sel, read_reg, write_reg register-bus select and strobes
//   busaddress, busdata_out       word address / write data, change on accept only
//   busdata_in                    read data from the decoder
//   busy                          transaction in flight (state != IDLE)
// Optional feature: define GPIO_BUS_POSTED_WRITE_EN to add a one-entry posted
//   write buffer that accepts a write while a transaction is in flight.
module gpio_bus_initiator #(
    parameter int unsigned AddrWidth      = 16,
    parameter int unsigned BusWidth       = 32,
    parameter int unsigned StrobeWidth    = 1,
    parameter int unsigned ReadLatency    = 5,
    parameter int unsigned WriteHold      = 5,
    parameter int unsigned RecoveryCycles = 2
) (
    input  logic                 reg_clk,
    input  logic                 reset_in,
    input  logic [AddrWidth-3:0] avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [BusWidth-1:0]  avs_writedata,
    output logic                 avs_waitrequest,
    output logic [BusWidth-1:0]  avs_readdata,
    output logic                 avs_readdatavalid,
    output logic                 chip_sel,
    output logic                 read_reg,
    output logic                 write_reg,
    output logic [AddrWidth-3:0] busaddress,
    output logic [BusWidth-1:0]  busdata_out,
    input  logic [BusWidth-1:0]  busdata_in,
    output logic                 busy
);

    localparam int unsigned WordAw   = AddrWidth - 2;
    localparam int unsigned MaxRw    = (ReadLatency > WriteHold) ? ReadLatency : WriteHold;
    localparam int unsigned MaxCnt   = (MaxRw > RecoveryCycles) ? MaxRw : RecoveryCycles;
    localparam int unsigned CntWidth = $clog2(MaxCnt + 1);

    // Counter reload values; each phase counts down to zero inclusive.
    // Strobe plus wait spans Latency+1 cycles so the sample edge ends cycle Latency+1.
    localparam logic [CntWidth-1:0] StrobeLoad  = CntWidth'(StrobeWidth - 1);
    localparam logic [CntWidth-1:0] RdWaitLoad  = CntWidth'(ReadLatency - StrobeWidth);
    localparam logic [CntWidth-1:0] WrWaitLoad  = CntWidth'(WriteHold - StrobeWidth);
    localparam logic [CntWidth-1:0] RecoverLoad = CntWidth'(RecoveryCycles - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STROBE  = 2'd1,
        S_WAIT    = 2'd2,
        S_RECOVER = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;

    logic                 op_rd_q, op_rd_d;
    logic [WordAw-1:0]    addr_q, addr_d;
    logic [BusWidth-1:0]  wdata_q, wdata_d;
    logic [BusWidth-1:0]  rdata_q, rdata_d;

    logic                 chip_sel_q, chip_sel_d;
    logic                 read_reg_q, read_reg_d;
    logic                 write_reg_q, write_reg_d;
    logic                 rdv_q, rdv_d;
    logic                 busy_q, busy_d;

    // Candidate transaction to launch from IDLE (buffered write or Avalon request).
    logic                 req_c;
    logic                 req_rd_c;
    logic [WordAw-1:0]    req_addr_c;
    logic [BusWidth-1:0]  req_data_c;

    logic                 launch;
    logic                 capture;

`ifdef GPIO_BUS_POSTED_WRITE_EN
    logic                 buf_valid_q, buf_valid_d;
    logic [WordAw-1:0]    buf_addr_q, buf_addr_d;
    logic [BusWidth-1:0]  buf_data_q, buf_data_d;
    logic                 buf_fill;

    // A pending buffered write is older than anything on the Avalon port.
    always_comb begin
        req_c      = 1'b0;
        req_rd_c   = 1'b0;
        req_addr_c = avs_address;
        req_data_c = avs_writedata;
        if (buf_valid_q) begin
            req_c      = 1'b1;
            req_addr_c = buf_addr_q;
            req_data_c = buf_data_q;
        end else begin
            req_c    = avs_read | avs_write;
            req_rd_c = avs_read & ~avs_write;
        end
    end

    // Fill while a transaction is in flight; drain on the launch from IDLE.
    always_comb begin
        buf_fill    = (state_q != S_IDLE) & avs_write & ~buf_valid_q;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        if (buf_fill) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = avs_address;
            buf_data_d  = avs_writedata;
        end else if (launch && buf_valid_q) begin
            buf_valid_d = 1'b0;
        end
    end

    // Posted write buffer registers.
    always_ff @(posedge reg_clk) begin
        if (reset_in) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
        end
    end
`else
    // Without buffering, only the Avalon port can launch; write wins a tie.
    always_comb begin
        req_c      = avs_read | avs_write;
        req_rd_c   = avs_read & ~avs_write;
        req_addr_c = avs_address;
        req_data_c = avs_writedata;
    end
`endif

    // State and phase counter register.
    always_ff @(posedge reg_clk) begin
        if (reset_in) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter and transaction-capture logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        launch  = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_c) begin
                    launch  = 1'b1;
                    state_d = S_STROBE;
                    cnt_d   = StrobeLoad;
                end
            end
            S_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = S_WAIT;
                    cnt_d   = op_rd_q ? RdWaitLoad : WrWaitLoad;
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    capture = op_rd_q;
                    state_d = S_RECOVER;
                    cnt_d   = RecoverLoad;
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
            S_RECOVER: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        op_rd_d = launch ? req_rd_c   : op_rd_q;
        addr_d  = launch ? req_addr_c : addr_q;
        wdata_d = launch ? req_data_c : wdata_q;
        rdata_d = capture ? busdata_in : rdata_q;
    end

    // Output decode: bus outputs are registered from the next state; only
    // waitrequest is combinational so IDLE can accept in the request cycle.
    always_comb begin
        chip_sel_d  = (state_d == S_STROBE) || (state_d == S_WAIT);
        read_reg_d  = (state_d == S_STROBE) && op_rd_d;
        write_reg_d = (state_d == S_STROBE) && !op_rd_d;
        rdv_d       = capture;
        busy_d      = (state_d != S_IDLE);

        avs_waitrequest = 1'b1;
        if (!reset_in) begin
`ifdef GPIO_BUS_POSTED_WRITE_EN
            if (state_q == S_IDLE) begin
                avs_waitrequest = buf_valid_q | ~(avs_read | avs_write);
            end else begin
                avs_waitrequest = ~(avs_write & ~buf_valid_q);
            end
`else
            if (state_q == S_IDLE) begin
                avs_waitrequest = ~(avs_read | avs_write);
            end
`endif
        end
    end

    // Datapath and output registers.
    always_ff @(posedge reg_clk) begin
        if (reset_in) begin
            op_rd_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            chip_sel_q  <= 1'b0;
            read_reg_q  <= 1'b0;
            write_reg_q <= 1'b0;
            rdv_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            op_rd_q     <= op_rd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            chip_sel_q  <= chip_sel_d;
            read_reg_q  <= read_reg_d;
            write_reg_q <= write_reg_d;
            rdv_q       <= rdv_d;
            busy_q      <= busy_d;
        end
    end

    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rdv_q;
    assign chip_sel          = chip_sel_q;
    assign read_reg          = read_reg_q;
    assign write_reg         = write_reg_q;
    assign busaddress        = addr_q;
    assign busdata_out       = wdata_q;
    assign busy              = busy_q;

endmodule
